mmcm_reset_seq: RTL and testbench



---
 rtl/mmcm_reset_seq_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/mmcm_reset_seq.sv | 128 ++++++++++++
 tb/tb_mmcm_reset_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_reset_seq_pkg.sv
// Shared types and default timing for the MMCM reset/lock sequencer.
// Holds the state encodings, the default timing constants and the lock-loss counter width.
package mmcm_reset_seq_pkg;

   typedef enum logic [2:0] {
      StMrst   = 3'd0,
      StWaitLk = 3'd1,
      StStable = 3'd2,
      StRun    = 3'd3,
      StFault  = 3'd4
   } state_e;

   localparam int unsigned DEF_RST_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 125000;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_MAX_RETRIES   = 3;
   localparam int unsigned DEF_CNT_W         = 17;

   localparam int unsigned LOSS_CNT_W = 8;

   function automatic logic [LOSS_CNT_W-1:0] sat_inc_loss(input logic [LOSS_CNT_W-1:0] v);
      return (&v) ? v : v + LOSS_CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/mmcm_reset_seq.sv
// Reset/lock sequencer for the board MMCM: pulses the MMCM reset, waits for stable lock,
// then releases the system reset. Define MMCM_RESET_SEQ_LOSS_CNT_EN for the lock-loss counter.
module mmcm_reset_seq
   import mmcm_reset_seq_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mmcm_locked,
   input  logic       clear_fault,
   output logic       mmcm_rst,
   output logic       sys_rst_n,
   output logic       fault,
   output logic [1:0] retry_cnt,
   output logic [2:0] state_o
`ifdef MMCM_RESET_SEQ_LOSS_CNT_EN
   ,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

   localparam logic [CNT_W-1:0] LP_RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LP_STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [1:0]       LP_RETRY_LAST  = 2'(MAX_RETRIES - 1);

   state_e           r_state;
   state_e           w_state_d;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_d;
   logic [1:0]       r_retry;
   logic [1:0]       w_retry_d;
   logic             r_sys_rst_n;
   logic             w_lk_s;

   sync_2ff #(
      .RESET_VAL(1'b0)
   ) u_sync_locked (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (mmcm_locked),
      .o_q  (w_lk_s)
   );

   always_comb begin
      w_state_d = r_state;
      w_retry_d = r_retry;
      unique case (r_state)
         StMrst: begin
            if (r_timer == LP_RST_LAST) w_state_d = StWaitLk;
         end
         StWaitLk: begin
            // Lock seen on the timeout cycle still wins.
            if (w_lk_s) begin
               w_state_d = StStable;
            end else if (r_timer == LP_LOCK_LAST) begin
               if (r_retry < LP_RETRY_LAST) begin
                  w_retry_d = r_retry + 2'd1;
                  w_state_d = StMrst;
               end else begin
                  w_state_d = StFault;
               end
            end
         end
         StStable: begin
            if (!w_lk_s) w_state_d = StWaitLk;
            else if (r_timer == LP_STABLE_LAST) w_state_d = StRun;
         end
         StRun: begin
            if (!w_lk_s) w_state_d = StMrst;
         end
         StFault: begin
            if (clear_fault) begin
               w_state_d = StMrst;
               w_retry_d = 2'd0;
            end
         end
         default: w_state_d = StMrst;
      endcase
      if (w_state_d == StRun) w_retry_d = 2'd0;
   end

   always_comb begin
      w_timer_d = r_timer;
      if (w_state_d != r_state) w_timer_d = '0;
      else if (!(&r_timer))     w_timer_d = r_timer + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StMrst;
         r_timer     <= '0;
         r_retry     <= 2'd0;
         r_sys_rst_n <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_timer     <= w_timer_d;
         r_retry     <= w_retry_d;
         r_sys_rst_n <= (w_state_d == StRun);
      end
   end

   assign mmcm_rst  = (r_state == StMrst) || (r_state == StFault);
   assign fault     = (r_state == StFault);
   assign sys_rst_n = r_sys_rst_n;
   assign retry_cnt = r_retry;
   assign state_o   = r_state;

`ifdef MMCM_RESET_SEQ_LOSS_CNT_EN
   logic [LOSS_CNT_W-1:0] r_loss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_loss_cnt <= '0;
      end else if ((r_state == StRun) && (w_state_d == StMrst)) begin
         r_loss_cnt <= sat_inc_loss(r_loss_cnt);
      end
   end

   assign lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: tb/tb_mmcm_reset_seq.sv
// Self-checking bench for mmcm_reset_seq: directed vector table, async-reset sequences and
// randomized lock activity checked against a behavioural model.
module tb_mmcm_reset_seq;

   localparam int RC = 4;
   localparam int TO = 20;
   localparam int SC = 8;
   localparam int MR = 3;

   localparam int PH_MRST   = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAULT  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mmcm_locked = 1'b0;
   logic       clear_fault = 1'b0;
   logic       mmcm_rst;
   logic       sys_rst_n;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [2:0] state_o;
`ifdef MMCM_RESET_SEQ_LOSS_CNT_EN
   logic [7:0] lock_loss_cnt;
`endif

   mmcm_reset_seq #(
      .RST_CYCLES   (RC),
      .LOCK_TIMEOUT (TO),
      .STABLE_CYCLES(SC),
      .MAX_RETRIES  (MR),
      .CNT_W        (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mmcm_locked  (mmcm_locked),
      .clear_fault  (clear_fault),
      .mmcm_rst     (mmcm_rst),
      .sys_rst_n    (sys_rst_n),
      .fault        (fault),
      .retry_cnt    (retry_cnt),
      .state_o      (state_o)
`ifdef MMCM_RESET_SEQ_LOSS_CNT_EN
      ,
      .lock_loss_cnt(lock_loss_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Behavioural model: phase, cycles spent in phase, retries, lock losses, sync pipeline.
   int m_ph, m_el, m_retry, m_llc;
   bit m_sync[2];

   function automatic void m_reset();
      m_ph = PH_MRST; m_el = 0; m_retry = 0; m_llc = 0;
      m_sync[0] = 1'b0; m_sync[1] = 1'b0;
   endfunction

   function automatic void m_step(input bit lk, input bit clr);
      bit lk_s;
      int nxt;
      lk_s = m_sync[1];
      m_sync[1] = m_sync[0];
      m_sync[0] = lk;
      nxt = m_ph;
      if (m_ph == PH_MRST) begin
         if (m_el == RC - 1) nxt = PH_WAIT;
      end else if (m_ph == PH_WAIT) begin
         if (lk_s) nxt = PH_STABLE;
         else if (m_el == TO - 1) begin
            if (m_retry < MR - 1) begin m_retry++; nxt = PH_MRST; end
            else nxt = PH_FAULT;
         end
      end else if (m_ph == PH_STABLE) begin
         if (!lk_s) nxt = PH_WAIT;
         else if (m_el == SC - 1) nxt = PH_RUN;
      end else if (m_ph == PH_RUN) begin
         if (!lk_s) begin nxt = PH_MRST; m_llc = (m_llc >= 255) ? 255 : m_llc + 1; end
      end else if (clr) begin
         nxt = PH_MRST; m_retry = 0;
      end
      if (nxt == PH_RUN) m_retry = 0;
      m_el = (nxt != m_ph) ? 0 : m_el + 1;
      m_ph = nxt;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cmp_model(input string nm);
      chk({nm, " state"}, int'(state_o), m_ph);
      chk({nm, " mmcm_rst"}, int'(mmcm_rst), int'(m_ph == PH_MRST || m_ph == PH_FAULT));
      chk({nm, " sys_rst_n"}, int'(sys_rst_n), int'(m_ph == PH_RUN));
      chk({nm, " fault"}, int'(fault), int'(m_ph == PH_FAULT));
      chk({nm, " retry_cnt"}, int'(retry_cnt), m_retry);
`ifdef MMCM_RESET_SEQ_LOSS_CNT_EN
      chk({nm, " lock_loss_cnt"}, int'(lock_loss_cnt), m_llc);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      m_step(mmcm_locked, clear_fault);
      #1;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " state"}, int'(state_o), PH_MRST);
      chk({nm, " mmcm_rst"}, int'(mmcm_rst), 1);
      chk({nm, " sys_rst_n"}, int'(sys_rst_n), 0);
      chk({nm, " fault"}, int'(fault), 0);
      chk({nm, " retry_cnt"}, int'(retry_cnt), 0);
   endtask

   // Assert rst_n between edges (called at posedge+1), check, release before the next edge.
   task automatic async_reset(input string nm);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      chk_reset_vals(nm);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_phase(input string nm, input int ph, input int budget);
      int i;
      for (i = 0; i < budget && m_ph != ph; i++) begin
         tick();
         cmp_model(nm);
      end
      if (m_ph != ph) chk({nm, " reach phase"}, m_ph, ph);
   endtask

   typedef struct {
      int n;
      bit lk;
      bit clr;
      int st;
      bit mrst;
      bit sys;
      bit flt;
      int rty;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int run_left;
      // Nominal bring-up (lock 5 cycles after mmcm_rst falls)
      tbl.push_back('{3,  0, 0, 0, 1, 0, 0, 0});
      tbl.push_back('{1,  0, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{5,  0, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{2,  1, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{7,  1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0, 3, 0, 1, 0, 0});
      tbl.push_back('{5,  1, 0, 3, 0, 1, 0, 0});
      // Lock loss in RUN, then three timeouts into FAULT
      tbl.push_back('{2,  0, 0, 3, 0, 1, 0, 0});
      tbl.push_back('{1,  0, 0, 0, 1, 0, 0, 0});
      tbl.push_back('{3,  0, 0, 0, 1, 0, 0, 0});
      tbl.push_back('{1,  0, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{19, 0, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{1,  0, 0, 0, 1, 0, 0, 1});
      tbl.push_back('{4,  0, 0, 1, 0, 0, 0, 1});
      tbl.push_back('{20, 0, 0, 0, 1, 0, 0, 2});
      tbl.push_back('{4,  0, 0, 1, 0, 0, 0, 2});
      tbl.push_back('{20, 0, 0, 4, 1, 0, 1, 2});
      tbl.push_back('{5,  1, 0, 4, 1, 0, 1, 2});
      tbl.push_back('{1,  1, 1, 0, 1, 0, 0, 0});
      // Restart, then a one-cycle lock glitch in STABLE
      tbl.push_back('{4,  1, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{3,  1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{1,  0, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{7,  1, 0, 2, 0, 0, 0, 0});
      tbl.push_back('{1,  1, 0, 3, 0, 1, 0, 0});
      // One timeout, then lock arriving exactly on the second timeout cycle
      tbl.push_back('{3,  0, 0, 0, 1, 0, 0, 0});
      tbl.push_back('{4,  0, 0, 1, 0, 0, 0, 0});
      tbl.push_back('{20, 0, 0, 0, 1, 0, 0, 1});
      tbl.push_back('{4,  0, 0, 1, 0, 0, 0, 1});
      tbl.push_back('{17, 0, 0, 1, 0, 0, 0, 1});
      tbl.push_back('{2,  1, 0, 1, 0, 0, 0, 1});
      tbl.push_back('{1,  1, 0, 2, 0, 0, 0, 1});
      tbl.push_back('{8,  1, 0, 3, 0, 1, 0, 0});

      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         mmcm_locked = tbl[i].lk;
         clear_fault = tbl[i].clr;
         for (int k = 0; k < tbl[i].n; k++) begin
            tick();
            clear_fault = 1'b0;
         end
         chk($sformatf("vec%0d state", i), int'(state_o), tbl[i].st);
         chk($sformatf("vec%0d mmcm_rst", i), int'(mmcm_rst), int'(tbl[i].mrst));
         chk($sformatf("vec%0d sys_rst_n", i), int'(sys_rst_n), int'(tbl[i].sys));
         chk($sformatf("vec%0d fault", i), int'(fault), int'(tbl[i].flt));
         chk($sformatf("vec%0d retry_cnt", i), int'(retry_cnt), tbl[i].rty);
      end

      // Async reset in RUN, then in STABLE
      async_reset("arst_run");
      mmcm_locked = 1'b1;
      wait_phase("to_stable", PH_STABLE, 20);
      tick();
      cmp_model("stable");
      async_reset("arst_stable");
      wait_phase("restart", PH_RUN, 40);
      cmp_model("restart_run");

      // Randomized lock activity against the model
      run_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (run_left == 0) begin
            mmcm_locked = ($urandom_range(0, 9) < 7);
            run_left = $urandom_range(1, 30);
         end
         run_left--;
         clear_fault = ($urandom_range(0, 19) == 0);
         tick();
         cmp_model("rnd");
      end
      clear_fault = 1'b0;

`ifdef MMCM_RESET_SEQ_LOSS_CNT_EN
      async_reset("arst_llc");
      chk("llc after reset", int'(lock_loss_cnt), 0);
      mmcm_locked = 1'b1;
      wait_phase("llc_run", PH_RUN, 40);
      for (int l = 0; l < 300; l++) begin
         mmcm_locked = 1'b0;
         repeat (3) begin tick(); cmp_model("llc_drop"); end
         mmcm_locked = 1'b1;
         repeat (13) begin tick(); cmp_model("llc_relock"); end
         if (l == 0) chk("llc first loss", int'(lock_loss_cnt), 1);
      end
      chk("llc saturated", int'(lock_loss_cnt), 255);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
